// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor (2-bit counters indexed by PC) plus execute-stage branch resolution.
// Predict/resolve are combinational (0 cycles); training and perf counters land next edge; no backpressure.
module branch_predict_unit #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int IDX_LSB = 2,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  pcF,
  output logic             predict_takenF,
  input  logic             validE,
  input  logic [2:0]       funct3E,
  input  logic [XLEN-1:0]  pcE,
  input  logic [XLEN-1:0]  rs1E,
  input  logic [XLEN-1:0]  rs2E,
  input  logic             predictedE,
  output logic             takenE,
  output logic             mispredictE,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [ENTRIES-1:0][1:0] r_table;
  logic [CNT_W-1:0]        r_branch_cnt;
  logic [CNT_W-1:0]        r_mispredict_cnt;

  logic [IDX_W-1:0] w_idx_f;
  logic [IDX_W-1:0] w_idx_e;
  logic [1:0]       w_entry_e;
  logic             w_eq;
  logic             w_lt_s;
  logic             w_lt_u;
  logic             w_cond;
  logic             w_legal;
  logic             w_resolve;
  logic             w_unused;

  assign w_idx_f   = pcF[IDX_LSB +: IDX_W];
  assign w_idx_e   = pcE[IDX_LSB +: IDX_W];
  assign w_entry_e = r_table[w_idx_e];
  // Only the index slice of each PC is consumed; there are no tags.
  assign w_unused  = ^{pcF, pcE};

  assign w_eq   = (rs1E == rs2E);
  assign w_lt_s = ($signed(rs1E) < $signed(rs2E));
  assign w_lt_u = (rs1E < rs2E);

  always_comb begin
    w_cond  = 1'b0;
    w_legal = 1'b1;
    case (funct3E)
      3'b000:  w_cond = w_eq;
      3'b001:  w_cond = ~w_eq;
      3'b100:  w_cond = w_lt_s;
      3'b101:  w_cond = ~w_lt_s;
      3'b110:  w_cond = w_lt_u;
      3'b111:  w_cond = ~w_lt_u;
      default: w_legal = 1'b0;
    endcase
  end

  assign w_resolve   = validE & w_legal;
  assign takenE      = w_resolve & w_cond;
  assign mispredictE = w_resolve & (w_cond ^ predictedE);

  // Read uses the registered table, so a same-cycle train at this index is not bypassed.
  assign predict_takenF = r_table[w_idx_f][1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_table <= {ENTRIES{2'b01}};
    end else if (w_resolve) begin
      if (w_cond && (w_entry_e != 2'b11)) begin
        r_table[w_idx_e] <= w_entry_e + 2'd1;
      end else if (!w_cond && (w_entry_e != 2'b00)) begin
        r_table[w_idx_e] <= w_entry_e - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else begin
      if (w_resolve && !(&r_branch_cnt)) begin
        r_branch_cnt <= r_branch_cnt + CNT_ONE;
      end
      if (mispredictE && !(&r_mispredict_cnt)) begin
        r_mispredict_cnt <= r_mispredict_cnt + CNT_ONE;
      end
    end
  end

  assign branch_cnt     = r_branch_cnt;
  assign mispredict_cnt = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Randomized + directed bench for branch_predict_unit against an abstract predictor model.
// Two instances share stimulus: default widths, and a 4-bit perf-counter variant for saturation.
module tb_branch_predict_unit;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 64;
  localparam int IDX_LSB = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] pcF = '0;
  logic        validE = 1'b0;
  logic [2:0]  funct3E = 3'b000;
  logic [31:0] pcE = '0;
  logic [31:0] rs1E = '0;
  logic [31:0] rs2E = '0;
  logic        predictedE = 1'b0;

  logic        pred, taken, mis;
  logic [31:0] bc, mc;
  logic        pred4, taken4, mis4;
  logic [3:0]  bc4, mc4;

  always #5 clk = ~clk;

  branch_predict_unit #(.XLEN(XLEN), .ENTRIES(ENTRIES), .IDX_LSB(IDX_LSB), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .pcF(pcF), .predict_takenF(pred),
    .validE(validE), .funct3E(funct3E), .pcE(pcE), .rs1E(rs1E), .rs2E(rs2E),
    .predictedE(predictedE), .takenE(taken), .mispredictE(mis),
    .branch_cnt(bc), .mispredict_cnt(mc)
  );

  branch_predict_unit #(.XLEN(XLEN), .ENTRIES(ENTRIES), .IDX_LSB(IDX_LSB), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .pcF(pcF), .predict_takenF(pred4),
    .validE(validE), .funct3E(funct3E), .pcE(pcE), .rs1E(rs1E), .rs2E(rs2E),
    .predictedE(predictedE), .takenE(taken4), .mispredictE(mis4),
    .branch_cnt(bc4), .mispredict_cnt(mc4)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int     tbl [ENTRIES];
  longint m_bc, m_mc;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> IDX_LSB) % ENTRIES);
  endfunction

  function automatic bit m_resolve();
    return validE && (funct3E inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7});
  endfunction

  function automatic bit m_taken();
    longint sa, sb;
    sa = longint'($signed(rs1E));
    sb = longint'($signed(rs2E));
    if (!m_resolve()) return 1'b0;
    case (funct3E)
      3'd0:    return rs1E == rs2E;
      3'd1:    return rs1E != rs2E;
      3'd4:    return sa < sb;
      3'd5:    return sa >= sb;
      3'd6:    return longint'(rs1E) < longint'(rs2E);
      default: return longint'(rs1E) >= longint'(rs2E);
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (tbl[i]) tbl[i] = 1;
      m_bc = 0;
      m_mc = 0;
    end else if (m_resolve()) begin
      int k;
      bit t;
      k = idx_of(pcE);
      t = m_taken();
      tbl[k] = t ? ((tbl[k] < 3) ? tbl[k] + 1 : 3) : ((tbl[k] > 0) ? tbl[k] - 1 : 0);
      m_bc++;
      if (t != predictedE) m_mc++;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("takenE", taken, m_taken());
      chk("mispredictE", mis, m_resolve() && (m_taken() != predictedE));
      chk("predict_takenF", pred, tbl[idx_of(pcF)] >= 2);
      chk("branch_cnt", bc, m_bc & 64'hFFFF_FFFF);
      chk("mispredict_cnt", mc, m_mc & 64'hFFFF_FFFF);
      chk("branch_cnt4", bc4, (m_bc > 15) ? 15 : m_bc);
      chk("mispredict_cnt4", mc4, (m_mc > 15) ? 15 : m_mc);
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int pe [4] = '{0, 0, 1, 1};
    int me [4] = '{1, 1, 0, 0};
    int pf [4] = '{1, 1, 1, 1};
    int pf0[4] = '{0, 1, 1, 1};
    int en [4] = '{2, 3, 3, 3};
    int ne [3] = '{2, 1, 0};
    int pf2[3] = '{1, 1, 0};
    longint sb;

    // Reset and sweep every index.
    #2 rst_n = 1'b0;
    go(); go();
    rst_n = 1'b1;
    for (int i = 0; i < ENTRIES; i++) begin
      pcF = ($urandom & 32'hFFFF_FF00) | (i << IDX_LSB) | ($urandom & 32'h3);
      pcF[IDX_LSB+6 +: 2] = 2'b00;
      #1 chk("reset_predict", pred, 0);
    end
    chk("reset_branch_cnt", bc, 0);
    chk("reset_mispredict_cnt", mc, 0);

    // Comparison corners.
    go();
    pcE = 32'h100; validE = 1'b1; predictedE = 1'b0;
    rs1E = 32'h8000_0000; rs2E = 32'h0000_0001;
    funct3E = 3'b100; #1 chk("blt_corner", taken, 1);
    funct3E = 3'b110; #1 chk("bltu_corner", taken, 0);
    rs1E = 32'hFFFF_FFFF; rs2E = 32'hFFFF_FFFF;
    funct3E = 3'b000; #1 chk("beq_corner", taken, 1);
    funct3E = 3'b101; #1 chk("bge_corner", taken, 1);

    // Training saturation at pc 0x40.
    go();
    pcF = 32'h40; pcE = 32'h40; funct3E = 3'b000; rs1E = 0; rs2E = 0; validE = 1'b1;
    for (int k = 0; k < 4; k++) begin
      predictedE = pe[k][0];
      #1 chk("train_mispredict", mis, me[k]);
      chk("train_predict_before", pred, pf0[k]);
      @(posedge clk); #1;
      chk("train_model_entry", tbl[16], en[k]);
      chk("train_predict_after", pred, pf[k]);
    end
    rs2E = 32'h1; predictedE = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 chk("untrain_mispredict", mis, 1);
      chk("untrain_predict", pred, pf2[k]);
      @(posedge clk); #1;
      chk("untrain_model_entry", tbl[16], ne[k]);
    end
    validE = 1'b0;
    #1 chk("untrain_final_predict", pred, 0);

    // Illegal funct3 and valid gating.
    sb = m_bc;
    validE = 1'b1; funct3E = 3'b010; rs1E = 5; rs2E = 5; predictedE = 1'b1;
    #1 chk("illegal_taken", taken, 0);
    chk("illegal_mispredict", mis, 0);
    @(posedge clk); #1;
    chk("illegal_no_count", bc, sb);
    chk("illegal_no_train", pred, 0);
    validE = 1'b0; funct3E = 3'b000;
    #1 chk("invalid_taken", taken, 0);
    @(posedge clk); #1;
    chk("invalid_no_count", bc, sb);

    // Same-cycle read/write at 0x80, then asynchronous reset mid-cycle.
    pcF = 32'h80; pcE = 32'h80; validE = 1'b1; predictedE = 1'b0;
    #1 chk("same_cycle_old", pred, 0);
    @(posedge clk); #1;
    chk("same_cycle_next", pred, 1);
    validE = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk("async_rst_predict", pred, 0);
    chk("async_rst_branch_cnt", bc, 0);
    chk("async_rst_mispredict_cnt", mc, 0);
    chk("async_rst_branch_cnt4", bc4, 0);
    go(); go();
    rst_n = 1'b1;

    // 20 mispredicted resolves: 4-bit counters stop at 0xF.
    validE = 1'b1; funct3E = 3'b000; rs1E = 7; rs2E = 7; predictedE = 1'b0;
    for (int k = 0; k < 20; k++) begin
      pcE = $urandom;
      @(posedge clk); #1;
    end
    validE = 1'b0;
    #1 chk("sat_branch_cnt32", bc, 20);
    chk("sat_mispredict_cnt32", mc, 20);
    chk("sat_branch_cnt4", bc4, 15);
    chk("sat_mispredict_cnt4", mc4, 15);

    // Randomized traffic with aliasing PCs and occasional mid-cycle resets.
    for (int n = 0; n < 2000; n++) begin
      go();
      pcF        = ($urandom & 32'h0030_0000) | ($urandom_range(0, 7) << IDX_LSB) | ($urandom & 32'h3);
      pcE        = ($urandom & 32'h0030_0000) | ($urandom_range(0, 7) << IDX_LSB) | ($urandom & 32'h3);
      validE     = ($urandom_range(0, 9) < 8);
      funct3E    = 3'($urandom);
      predictedE = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       begin rs1E = $urandom; rs2E = rs1E; end
        1:       begin rs1E = 32'h8000_0000 ^ ($urandom & 32'h3); rs2E = $urandom & 32'h3; end
        default: begin rs1E = $urandom; rs2E = $urandom; end
      endcase
      if ($urandom_range(0, 249) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    go();
    validE = 1'b0;
    go();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
